stk_eng_if: RTL and testbench

Per-engine command initiator for the stack pipeline. Accepts one push/pop request at a time from a client, drives it onto that engine's command slot, and holds it until the pipeline acknowledges. It then waits for the response addressed to its engine on the shared response bus and returns a single completion to the client. One instance exists per engine (`ENG_ID`), all sharing the pipeline's broadcast response bus.

---
 rtl/cfg_pkg.sv | 4 +
 rtl/stk_pkg.sv | 26 ++
 rtl/stk_eng_if_tmr.sv | 25 ++
 rtl/stk_eng_if.sv | 136 +++++++++++++
 tb/tb_stk_eng_if.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_pkg.sv
// System configuration shared by the stack pipeline and its engine interfaces.
package cfg_pkg;
   localparam int ENGS_N = 4;
endpackage

// File: rtl/stk_pkg.sv
// Stack pipeline types: opcodes, response status and engine-interface FSM state.
package stk_pkg;
   localparam int DAT_W                 = 128;
   localparam int ENG_TIMEOUT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      OP_PUSH = 2'd0,
      OP_POP  = 2'd1,
      OP_PEEK = 2'd2,
      OP_CLR  = 2'd3
   } opcode_t;

   typedef enum logic [1:0] {
      ST_OK    = 2'd0,
      ST_EMPTY = 2'd1,
      ST_FULL  = 2'd2,
      ST_ERR   = 2'd3
   } status_t;

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_CMD  = 4'b0010,
      S_RSP  = 4'b0100,
      S_CPL  = 4'b1000
   } eng_if_state_t;
endpackage

// File: rtl/stk_eng_if_tmr.sv
// Response-timeout counter: counts RSP cycles, flags when it reaches all-ones.
module stk_eng_if_tmr #(
   parameter int TIMEOUT_W = 8
) (
   input  logic clk,
   input  logic arst_n,
   input  logic clr,
   input  logic inc,
   output logic o_expired
);
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)      cnt_d = '0;
      else if (inc) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign o_expired = &cnt_q;
endmodule

// File: rtl/stk_eng_if.sv
// Per-engine command initiator: one outstanding push/pop, held until ack, then
// waits for this engine's broadcast response (or a timeout) and completes once.
module stk_eng_if
   import stk_pkg::*;
#(
   parameter int ENG_ID    = 0,
   parameter int TIMEOUT_W = ENG_TIMEOUT_W_DEFAULT
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       i_req_vld,
   input  opcode_t                    i_req_opcode,
   input  logic [DAT_W-1:0]           i_req_dat,
   output logic                       o_req_rdy,
   output logic                       o_cpl_vld,
   output logic [DAT_W-1:0]           o_cpl_dat,
   output status_t                    o_cpl_status,
   output logic                       o_cpl_timeout,
   input  logic                       i_cpl_rdy,
   output logic                       o_cmd_vld,
   output opcode_t                    o_cmd_opcode,
   output logic [DAT_W-1:0]           o_cmd_dat,
   input  logic                       i_cmd_ack,
   input  logic [cfg_pkg::ENGS_N-1:0] i_rsp_vld,
   input  logic [DAT_W-1:0]           i_rsp_dat,
   input  status_t                    i_rsp_status,
   output logic                       o_stray_err
);
   eng_if_state_t    state_q, state_d;
   opcode_t          cmd_op_q, cmd_op_d;
   logic [DAT_W-1:0] cmd_dat_q, cmd_dat_d;
   logic [DAT_W-1:0] cpl_dat_q, cpl_dat_d;
   status_t          cpl_st_q, cpl_st_d;
   logic             cpl_to_q, cpl_to_d;
   logic             stray_q, stray_d;
   logic             tmr_clr, tmr_inc, tmr_expired;
   logic             rsp_hit;

   assign rsp_hit = i_rsp_vld[ENG_ID];

   stk_eng_if_tmr #(.TIMEOUT_W(TIMEOUT_W)) u_tmr (
      .clk       (clk),
      .arst_n    (arst_n),
      .clr       (tmr_clr),
      .inc       (tmr_inc),
      .o_expired (tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      cmd_op_d  = cmd_op_q;
      cmd_dat_d = cmd_dat_q;
      cpl_dat_d = cpl_dat_q;
      cpl_st_d  = cpl_st_q;
      cpl_to_d  = cpl_to_q;
      stray_d   = stray_q;
      tmr_clr   = 1'b0;
      tmr_inc   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_req_vld) begin
               cmd_op_d  = i_req_opcode;
               cmd_dat_d = i_req_dat;
               state_d   = S_CMD;
            end
            if (rsp_hit) stray_d = 1'b1;
         end
         S_CMD: begin
            if (i_cmd_ack) begin
               tmr_clr = 1'b1;
               // A zero-latency pipeline may answer in the ack cycle itself.
               if (rsp_hit) begin
                  cpl_dat_d = i_rsp_dat;
                  cpl_st_d  = i_rsp_status;
                  cpl_to_d  = 1'b0;
                  state_d   = S_CPL;
               end else begin
                  state_d = S_RSP;
               end
            end else if (rsp_hit) begin
               stray_d = 1'b1;
            end
         end
         S_RSP: begin
            if (rsp_hit) begin
               cpl_dat_d = i_rsp_dat;
               cpl_st_d  = i_rsp_status;
               cpl_to_d  = 1'b0;
               state_d   = S_CPL;
            end else if (tmr_expired) begin
               cpl_dat_d = '0;
               cpl_st_d  = ST_OK;
               cpl_to_d  = 1'b1;
               state_d   = S_CPL;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         S_CPL: begin
            if (i_cpl_rdy) state_d = S_IDLE;
            if (rsp_hit)   stray_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= S_IDLE;
         cpl_to_q <= 1'b0;
         stray_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cpl_to_q <= cpl_to_d;
         stray_q  <= stray_d;
      end
   end

   // Datapath registers are qualified by the valids, so they carry no reset.
   always_ff @(posedge clk) begin
      cmd_op_q  <= cmd_op_d;
      cmd_dat_q <= cmd_dat_d;
      cpl_dat_q <= cpl_dat_d;
      cpl_st_q  <= cpl_st_d;
   end

   assign o_req_rdy     = (state_q == S_IDLE);
   assign o_cmd_vld     = (state_q == S_CMD);
   assign o_cpl_vld     = (state_q == S_CPL);
   assign o_cmd_opcode  = cmd_op_q;
   assign o_cmd_dat     = cmd_dat_q;
   assign o_cpl_dat     = cpl_dat_q;
   assign o_cpl_status  = cpl_st_q;
   assign o_cpl_timeout = cpl_to_q;
   assign o_stray_err   = stray_q;
endmodule

// File: tb/tb_stk_eng_if.sv
// Scoreboard bench for stk_eng_if (ENG_ID=2, ENGS_N=4, TIMEOUT_W=3).
module tb_stk_eng_if;
   import stk_pkg::*;

   localparam int ENG = 2;

   typedef struct {
      logic [127:0] dat;
      status_t      st;
      logic         to;
   } exp_t;

   logic         clk = 1'b0;
   logic         arst_n = 1'b0;
   logic         i_req_vld = 1'b0;
   opcode_t      i_req_opcode = OP_PUSH;
   logic [127:0] i_req_dat = '0;
   logic         o_req_rdy, o_cpl_vld, o_cpl_timeout, o_cmd_vld, o_stray_err;
   logic [127:0] o_cpl_dat, o_cmd_dat;
   status_t      o_cpl_status;
   opcode_t      o_cmd_opcode;
   logic         i_cpl_rdy = 1'b1;
   logic         i_cmd_ack = 1'b0;
   logic [3:0]   i_rsp_vld = '0;
   logic [127:0] i_rsp_dat = '0;
   status_t      i_rsp_status = ST_OK;

   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   stk_eng_if #(.ENG_ID(ENG), .TIMEOUT_W(3)) dut (
      .clk(clk), .arst_n(arst_n),
      .i_req_vld(i_req_vld), .i_req_opcode(i_req_opcode), .i_req_dat(i_req_dat),
      .o_req_rdy(o_req_rdy),
      .o_cpl_vld(o_cpl_vld), .o_cpl_dat(o_cpl_dat), .o_cpl_status(o_cpl_status),
      .o_cpl_timeout(o_cpl_timeout), .i_cpl_rdy(i_cpl_rdy),
      .o_cmd_vld(o_cmd_vld), .o_cmd_opcode(o_cmd_opcode), .o_cmd_dat(o_cmd_dat),
      .i_cmd_ack(i_cmd_ack),
      .i_rsp_vld(i_rsp_vld), .i_rsp_dat(i_rsp_dat), .i_rsp_status(i_rsp_status),
      .o_stray_err(o_stray_err)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Monitor: every consumed completion is matched against the scoreboard.
   always @(negedge clk) begin
      if (arst_n && o_cpl_vld && i_cpl_rdy) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cpl act=%0h exp=none", o_cpl_dat);
         end else begin
            mon_e = q.pop_front();
            chk("cpl_dat", o_cpl_dat, mon_e.dat);
            chk("cpl_status", 128'(o_cpl_status), 128'(mon_e.st));
            chk("cpl_timeout", 128'(o_cpl_timeout), 128'(mon_e.to));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input opcode_t op, input logic [127:0] d);
      i_req_vld = 1'b1; i_req_opcode = op; i_req_dat = d;
      tick();
      i_req_vld = 1'b0; i_req_dat = '0;
   endtask

   task automatic do_ack();
      i_cmd_ack = 1'b1;
      tick();
      i_cmd_ack = 1'b0;
   endtask

   task automatic rsp(input logic [3:0] v, input logic [127:0] d, input status_t s);
      i_rsp_vld = v; i_rsp_dat = d; i_rsp_status = s;
      tick();
      i_rsp_vld = '0; i_rsp_dat = '0; i_rsp_status = ST_OK;
   endtask

   task automatic push_exp(input logic [127:0] d, input status_t s, input logic t);
      exp_t e;
      e.dat = d; e.st = s; e.to = t;
      q.push_back(e);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst_req_rdy", 128'(o_req_rdy), 128'd1);
      chk("rst_cmd_vld", 128'(o_cmd_vld), 128'd0);
      chk("rst_cpl_vld", 128'(o_cpl_vld), 128'd0);
      chk("rst_timeout", 128'(o_cpl_timeout), 128'd0);
      chk("rst_stray", 128'(o_stray_err), 128'd0);
      tick();
      arst_n = 1'b1;
      tick();

      // Basic push: ack 2 cycles later, response 3 cycles after ack
      send_req(OP_PUSH, 128'hA5);
      @(negedge clk);
      chk("t1_cmd_vld", 128'(o_cmd_vld), 128'd1);
      chk("t1_cmd_dat", o_cmd_dat, 128'hA5);
      chk("t1_req_rdy", 128'(o_req_rdy), 128'd0);
      tick();
      do_ack();
      push_exp(128'hA5, ST_OK, 1'b0);
      tick();
      tick();
      rsp(4'b0100, 128'hA5, ST_OK);
      @(negedge clk);
      chk("t1_cpl_vld", 128'(o_cpl_vld), 128'd1);
      chk("t1_req_rdy_cpl", 128'(o_req_rdy), 128'd0);
      tick();
      @(negedge clk);
      chk("t1_req_rdy_back", 128'(o_req_rdy), 128'd1);
      chk("t1_cpl_once", 128'(o_cpl_vld), 128'd0);

      // Ack backpressure, then ack and response in the same cycle
      send_req(OP_POP, 128'h1234_5678_9ABC_DEF0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_cmd_vld", 128'(o_cmd_vld), 128'd1);
         chk("t2_cmd_op", 128'(o_cmd_opcode), 128'(OP_POP));
         chk("t2_cmd_dat", o_cmd_dat, 128'h1234_5678_9ABC_DEF0);
         tick();
      end
      push_exp(128'hDEAD, ST_EMPTY, 1'b0);
      i_cmd_ack = 1'b1;
      rsp(4'b0100, 128'hDEAD, ST_EMPTY);
      i_cmd_ack = 1'b0;
      @(negedge clk);
      chk("t2_cpl_vld", 128'(o_cpl_vld), 128'd1);
      tick();

      // Response filtering: only bit ENG completes
      send_req(OP_PUSH, 128'h77);
      do_ack();
      for (int b = 0; b < 4; b++) begin
         if (b != ENG) begin
            rsp(4'(1 << b), 128'hBAD, ST_ERR);
            @(negedge clk);
            chk("t3_no_cpl", 128'(o_cpl_vld), 128'd0);
            chk("t3_no_stray", 128'(o_stray_err), 128'd0);
         end
      end
      push_exp(128'hBEEF, ST_FULL, 1'b0);
      rsp(4'b0100, 128'hBEEF, ST_FULL);
      @(negedge clk);
      chk("t3_cpl_vld", 128'(o_cpl_vld), 128'd1);
      tick();
      @(negedge clk);
      chk("t3_stray_clean", 128'(o_stray_err), 128'd0);

      // Timeout after 8 RSP cycles, completion stall, late response
      i_cpl_rdy = 1'b0;
      send_req(OP_POP, 128'h55);
      do_ack();
      push_exp(128'h0, ST_OK, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t4_wait_cpl", 128'(o_cpl_vld), 128'd0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_stall_vld", 128'(o_cpl_vld), 128'd1);
         chk("t4_stall_to", 128'(o_cpl_timeout), 128'd1);
         chk("t4_stall_dat", o_cpl_dat, 128'h0);
         chk("t4_stall_st", 128'(o_cpl_status), 128'(ST_OK));
         tick();
      end
      i_cpl_rdy = 1'b1;
      tick();
      rsp(4'b0100, 128'h99, ST_OK);
      @(negedge clk);
      chk("t4_stray_set", 128'(o_stray_err), 128'd1);
      tick();
      tick();
      @(negedge clk);
      chk("t4_stray_sticky", 128'(o_stray_err), 128'd1);
      chk("t4_late_no_cpl", 128'(o_cpl_vld), 128'd0);

      // Reset in RSP, then a normal transaction
      send_req(OP_PUSH, 128'h42);
      do_ack();
      tick();
      arst_n = 1'b0;
      @(negedge clk);
      chk("t5_req_rdy", 128'(o_req_rdy), 128'd1);
      chk("t5_cmd_vld", 128'(o_cmd_vld), 128'd0);
      chk("t5_cpl_vld", 128'(o_cpl_vld), 128'd0);
      chk("t5_timeout", 128'(o_cpl_timeout), 128'd0);
      chk("t5_stray", 128'(o_stray_err), 128'd0);
      tick();
      arst_n = 1'b1;
      tick();
      send_req(OP_PUSH, 128'hC0FFEE);
      tick();
      do_ack();
      push_exp(128'hC0FFEE, ST_OK, 1'b0);
      rsp(4'b0100, 128'hC0FFEE, ST_OK);
      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      chk("final_q_empty", 128'(q.size()), 128'd0);
      tick();
      @(negedge clk);
      chk("final_req_rdy", 128'(o_req_rdy), 128'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
